rr_grant_scheduler: RTL and testbench

//  8-way round-robin scheduler sharing one resource between 8 requesters.

---
 rtl/rr_grant_scheduler_pkg.sv | 37 +++
 rtl/rr_grant_scheduler_dec.sv | 16 +
 rtl/rr_grant_scheduler.sv | 111 +++++++++++
 tb/tb_rr_grant_scheduler.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rr_grant_scheduler_pkg.sv
// rtl/rr_grant_scheduler_pkg.sv - shared constants, state encoding and round-robin pick
package rr_grant_scheduler_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;
  localparam int HCW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Rotate req right so that requester last+1 sits at bit 0, take the lowest
  // set bit, then add the rotation back; the 3-bit add wraps 7 -> 0 naturally.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] last);
    logic [IDXW-1:0]   start;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDXW-1:0]   off;
    logic              found;
    start = last + 3'd1;
    dbl   = {req, req} >> start;
    rot   = dbl[NREQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        off   = k[IDXW-1:0];
        found = 1'b1;
      end
    end
    return start + off;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_dec.sv
// rtl/rr_grant_scheduler_dec.sv - 3-to-8 one-hot decoder with enable
module onehot_dec3to8
  import rr_grant_scheduler_pkg::*;
(
  input  logic            en,
  input  logic [IDXW-1:0] idx,
  output logic [NREQ-1:0] onehot
);

  // Single bit at position idx when enabled, all zeros otherwise
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - 8-way round-robin grant scheduler with hold limit
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_vld,
  output logic            timeout
);

  localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);

  state_t          state, state_next;
  logic [IDXW-1:0] last, last_next;
  logic [HCW-1:0]  hold_cnt, hold_cnt_next;
  logic [IDXW-1:0] grant_idx_next;
  logic            grant_vld_next;
  logic            timeout_next;
  logic [NREQ-1:0] grant_dec;

  logic owner_req;
  logic at_limit;
  logic start_grant;

  assign owner_req   = req[grant_idx];
  assign at_limit    = (hold_cnt == HOLD_LIM);
  assign start_grant = en && (|req);

  // Grant vector is decoded from the next index and registered with it,
  // so grant always matches grant_idx and is zero whenever grant_vld is low
  onehot_dec3to8 u_dec (
    .en     (grant_vld_next),
    .idx    (grant_idx_next),
    .onehot (grant_dec)
  );

  // State register; reset makes requester 0 first in line (last = 7)
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: GAP always lasts one cycle so consecutive grants never overlap
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_grant) state_next = ST_GRANT;
      ST_GRANT: if (!owner_req || at_limit) state_next = ST_GAP;
      ST_GAP:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, rotation pointer and hold counter
  always_comb begin
    grant_idx_next = grant_idx;
    grant_vld_next = grant_vld;
    timeout_next   = 1'b0;
    last_next      = last;
    hold_cnt_next  = hold_cnt;
    case (state)
      ST_IDLE: begin
        grant_vld_next = 1'b0;
        if (start_grant) begin
          grant_idx_next = rr_pick(req, last);
          grant_vld_next = 1'b1;
          hold_cnt_next  = 8'd1;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          grant_vld_next = 1'b0;
          last_next      = grant_idx;
        end else if (at_limit) begin
          grant_vld_next = 1'b0;
          last_next      = grant_idx;
          timeout_next   = 1'b1;
        end else begin
          hold_cnt_next  = hold_cnt + 8'd1;
        end
      end
      default: grant_vld_next = 1'b0;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
      timeout   <= 1'b0;
      last      <= 3'd7;
      hold_cnt  <= '0;
    end else begin
      grant     <= grant_dec;
      grant_idx <= grant_idx_next;
      grant_vld <= grant_vld_next;
      timeout   <= timeout_next;
      last      <= last_next;
      hold_cnt  <= hold_cnt_next;
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb/tb_rr_grant_scheduler.sv - directed self-checking bench for rr_grant_scheduler
module tb_rr_grant_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int checks;
  int failures;

  rr_grant_scheduler #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_grant(input string tag, input logic [7:0] g, input logic v,
                              input logic [2:0] idx, input logic to);
    check_eq({tag, ".grant"}, {24'd0, grant}, {24'd0, g});
    check_eq({tag, ".vld"}, {31'd0, grant_vld}, {31'd0, v});
    if (v) check_eq({tag, ".idx"}, {29'd0, grant_idx}, {29'd0, idx});
    check_eq({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] r3;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    en  = 1'b1;
    req = 8'hFF;
    @(negedge clk);

    // 1. reset held two cycles with every requester active
    step();
    expect_grant("rst_c1", 8'h00, 1'b0, 3'd0, 1'b0);
    step();
    expect_grant("rst_c2", 8'h00, 1'b0, 3'd0, 1'b0);
    check_eq("rst.idx", {29'd0, grant_idx}, 32'd0);
    rst = 1'b0;
    expect_grant("rst_fall", 8'h00, 1'b0, 3'd0, 1'b0);

    // 2. full rotation, each tenure ends by timeout
    step();
    for (int r = 0; r < 9; r++) begin
      r3 = 3'(r);
      for (int c = 0; c < 16; c++) begin
        expect_grant($sformatf("rot%0d_c%0d", r, c), 8'h01 << r3, 1'b1, r3, 1'b0);
        step();
        if (r == 8) break;
      end
      if (r == 8) break;
      expect_grant($sformatf("rot%0d_gap", r), 8'h00, 1'b0, 3'd0, 1'b1);
      step();
      expect_grant($sformatf("rot%0d_idle", r), 8'h00, 1'b0, 3'd0, 1'b0);
      step();
    end

    // 3. voluntary release by requester 2, then requester 5
    req = 8'h24;
    do_reset();
    step();
    expect_grant("rel_c1", 8'h04, 1'b1, 3'd2, 1'b0);
    step();
    expect_grant("rel_c2", 8'h04, 1'b1, 3'd2, 1'b0);
    step();
    expect_grant("rel_c3", 8'h04, 1'b1, 3'd2, 1'b0);
    req = 8'h20;
    step();
    expect_grant("rel_gap", 8'h00, 1'b0, 3'd0, 1'b0);
    step();
    expect_grant("rel_idle", 8'h00, 1'b0, 3'd0, 1'b0);
    step();
    expect_grant("rel_next", 8'h20, 1'b1, 3'd5, 1'b0);

    // 4. wrap-around: last=6, then 7, then 0
    req = 8'h40;
    do_reset();
    step();
    expect_grant("wrap_6", 8'h40, 1'b1, 3'd6, 1'b0);
    req = 8'h81;
    step();
    step();
    expect_grant("wrap_dead", 8'h00, 1'b0, 3'd0, 1'b0);
    step();
    expect_grant("wrap_7", 8'h80, 1'b1, 3'd7, 1'b0);
    req = 8'h01;
    step();
    step();
    step();
    expect_grant("wrap_0", 8'h01, 1'b1, 3'd0, 1'b0);

    // 5. reset mid-grant while requests change; priority restarts at 0
    rst = 1'b1;
    req = 8'hFE;
    step();
    expect_grant("midrst", 8'h00, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    req = 8'hFF;
    step();
    expect_grant("midrst_next", 8'h01, 1'b1, 3'd0, 1'b0);

    // 6. enable gating
    en  = 1'b0;
    req = 8'h10;
    do_reset();
    step();
    expect_grant("en0_c1", 8'h00, 1'b0, 3'd0, 1'b0);
    step();
    expect_grant("en0_c2", 8'h00, 1'b0, 3'd0, 1'b0);
    en = 1'b1;
    step();
    expect_grant("en1", 8'h10, 1'b1, 3'd4, 1'b0);
    en = 1'b0;
    step();
    expect_grant("en0_hold1", 8'h10, 1'b1, 3'd4, 1'b0);
    step();
    expect_grant("en0_hold2", 8'h10, 1'b1, 3'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
